clken_synth: RTL and testbench



---
 rtl/clken_pkg.sv | 22 ++
 rtl/clken_synth_if.sv | 15 +
 rtl/clken_chan.sv | 79 +++++++
 rtl/clken_synth.sv | 86 ++++++++
 tb/tb_clken_synth.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/clken_pkg.sv
// Shared constants, configuration status encoding and write validation
// for the clken_synth fractional clock-enable synthesiser.
package clken_pkg;

  localparam int ACC_W_DEF = 8;
  localparam int CH_W      = 3;

  typedef enum logic [1:0] {
    CFG_NONE = 2'b00,
    CFG_ACK  = 2'b01,
    CFG_ERR  = 2'b10
  } cfg_status_e;

  // A write is legal only for an existing channel with a nonzero divisor and M <= D.
  function automatic logic cfg_valid(input int unsigned ch,
                                     input int unsigned mul,
                                     input int unsigned div,
                                     input int unsigned channels);
    return (ch < channels) && (div != 32'd0) && (mul <= div);
  endfunction

endpackage

// File: rtl/clken_synth_if.sv
// Configuration write bus of clken_synth: write strobe, target channel,
// new M/D ratio and the one-cycle ack/err response.
interface clken_synth_if #(
  parameter int ACC_W = clken_pkg::ACC_W_DEF
);
  logic                       cfg_we;
  logic [clken_pkg::CH_W-1:0] cfg_ch;
  logic [ACC_W-1:0]           cfg_mul;
  logic [ACC_W-1:0]           cfg_div;
  logic                       cfg_ack;
  logic                       cfg_err;

  modport master (output cfg_we, cfg_ch, cfg_mul, cfg_div, input cfg_ack, cfg_err);
  modport slave  (input cfg_we, cfg_ch, cfg_mul, cfg_div, output cfg_ack, cfg_err);
endinterface

// File: rtl/clken_chan.sv
// One fractional enable channel: M/D phase accumulator with 0 and 180 degree strobes.
// The en180 comparator exists only when CLKEN_PHASE180_EN is defined; otherwise en180 is 0.
module clken_chan #(
  parameter int               ACC_W    = 8,
  parameter logic [ACC_W-1:0] MUL_INIT = {ACC_W{1'b0}},
  parameter logic [ACC_W-1:0] DIV_INIT = {ACC_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked,
  input  logic             load,
  input  logic [ACC_W-1:0] load_mul,
  input  logic [ACC_W-1:0] load_div,
  output logic             en,
  output logic             en180
);

  logic [ACC_W-1:0] mul_q, mul_d, div_q, div_d, acc_q, acc_d;
  logic             en_q, en_d, en180_q, en180_d;
  logic [ACC_W:0]   sum;
`ifdef CLKEN_PHASE180_EN
  logic [ACC_W-1:0] half;
`endif

  // Next-state: a load wins, accumulator parked at 0 until lock, M = 0 idles the channel
  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, mul_q};
    mul_d   = mul_q;
    div_d   = div_q;
    acc_d   = acc_q;
    en_d    = 1'b0;
    en180_d = 1'b0;
`ifdef CLKEN_PHASE180_EN
    half    = div_q >> 1;
`endif
    if (load) begin
      mul_d = load_mul;
      div_d = load_div;
      acc_d = {ACC_W{1'b0}};
    end else if (!locked) begin
      acc_d = {ACC_W{1'b0}};
    end else if (mul_q == {ACC_W{1'b0}}) begin
      acc_d = acc_q;
    end else begin
      if (sum >= {1'b0, div_q}) begin
        acc_d = ACC_W'(sum - {1'b0, div_q});
        en_d  = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
`ifdef CLKEN_PHASE180_EN
      // Half-period mark crossed either in this wrap or in the next one
      en180_d = ((acc_q < half) && (sum >= {1'b0, half})) ||
                (sum >= ({1'b0, div_q} + {1'b0, half}));
`endif
    end
  end

  // Channel state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_q   <= MUL_INIT;
      div_q   <= DIV_INIT;
      acc_q   <= {ACC_W{1'b0}};
      en_q    <= 1'b0;
      en180_q <= 1'b0;
    end else begin
      mul_q   <= mul_d;
      div_q   <= div_d;
      acc_q   <= acc_d;
      en_q    <= en_d;
      en180_q <= en180_d;
    end
  end

  assign en    = en_q;
  assign en180 = en180_q;

endmodule

// File: rtl/clken_synth.sv
// Multi-channel fractional clock-enable synthesiser with startup lock sequencer.
// Define CLKEN_PHASE180_EN to build the half-period (en180) strobes.
module clken_synth
  import clken_pkg::*;
#(
  parameter int                        CHANNELS = 2,
  parameter int                        ACC_W    = ACC_W_DEF,
  parameter int                        STARTUP  = 16,
  parameter logic [CHANNELS*ACC_W-1:0] MUL_INIT = {8'd3, 8'd2},
  parameter logic [CHANNELS*ACC_W-1:0] DIV_INIT = {8'd4, 8'd2}
) (
  input  logic                CLK,
  input  logic                RST,
  clken_synth_if.slave        cfg_bus,
  output logic                LOCKED,
  output logic [CHANNELS-1:0] en,
  output logic [CHANNELS-1:0] en180
);

  localparam int CNT_W = $clog2(STARTUP + 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                locked_q, locked_d;
  cfg_status_e         status_q, status_d;
  logic                wr_ok;
  logic [CHANNELS-1:0] load;

  // Lock counter and configuration write decode
  always_comb begin
    cnt_d    = cnt_q;
    locked_d = locked_q;
    if (!locked_q) begin
      cnt_d    = cnt_q + CNT_W'(1);
      locked_d = (cnt_q == CNT_W'(STARTUP - 1));
    end else begin
      cnt_d    = cnt_q;
    end
    wr_ok    = cfg_valid(32'(cfg_bus.cfg_ch), 32'(cfg_bus.cfg_mul),
                         32'(cfg_bus.cfg_div), 32'(CHANNELS));
    status_d = CFG_NONE;
    if (!cfg_bus.cfg_we) begin
      status_d = CFG_NONE;
    end else if (wr_ok) begin
      status_d = CFG_ACK;
    end else begin
      status_d = CFG_ERR;
    end
  end

  // Lock and handshake registers; RST drops any write issued in the same cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q    <= {CNT_W{1'b0}};
      locked_q <= 1'b0;
      status_q <= CFG_NONE;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      status_q <= status_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign load[i] = cfg_bus.cfg_we && wr_ok && (cfg_bus.cfg_ch == CH_W'(i));

    clken_chan #(
      .ACC_W    (ACC_W),
      .MUL_INIT (MUL_INIT[i*ACC_W +: ACC_W]),
      .DIV_INIT (DIV_INIT[i*ACC_W +: ACC_W])
    ) u_chan (
      .clk      (CLK),
      .rst      (RST),
      .locked   (locked_q),
      .load     (load[i]),
      .load_mul (cfg_bus.cfg_mul),
      .load_div (cfg_bus.cfg_div),
      .en       (en[i]),
      .en180    (en180[i])
    );
  end

  assign LOCKED          = locked_q;
  assign cfg_bus.cfg_ack = (status_q == CFG_ACK);
  assign cfg_bus.cfg_err = (status_q == CFG_ERR);

endmodule

// File: tb/tb_clken_synth.sv
// Scoreboard bench for clken_synth: directed and random cfg writes against an
// arithmetic phase model (strobe n fires when n*M crosses a multiple of D, or of D plus D/2).
module tb_clken_synth;
  import clken_pkg::*;

  localparam int CHANNELS = 2;
  localparam int ACC_W    = 8;
  localparam int STARTUP  = 16;

  logic                CLK;
  logic                RST;
  logic                LOCKED;
  logic [CHANNELS-1:0] en;
  logic [CHANNELS-1:0] en180;

  clken_synth_if #(.ACC_W(ACC_W)) cfg_bus ();

  clken_synth #(
    .CHANNELS (CHANNELS),
    .ACC_W    (ACC_W),
    .STARTUP  (STARTUP),
    .MUL_INIT ({8'd3, 8'd2}),
    .DIV_INIT ({8'd4, 8'd2})
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .cfg_bus (cfg_bus),
    .LOCKED  (LOCKED),
    .en      (en),
    .en180   (en180)
  );

  initial begin
    CLK = 1'b1;
    forever #5 CLK = ~CLK;
  end

  int          errors = 0;
  int          checks = 0;
  bit          sim_done = 1'b0;
  logic [6:0]  exp_q[$];   // {LOCKED, en180, en, cfg_err, cfg_ack} per cycle
  logic [1:0]  cfg_q[$];   // {err, ack} per accepted/rejected write

  // Reference model state
  int     m_mul[CHANNELS];
  int     m_div[CHANNELS];
  longint m_n[CHANNELS];
  int     m_cnt;
  bit     m_locked;

  function automatic bit en_at(longint m, longint d, longint n);
    return ((n * m) / d) > (((n - 1) * m) / d);
  endfunction

  // Number of marks k*d+h (k >= 0) at or below phase x
  function automatic longint marks(longint x, longint h, longint d);
    return (x >= h) ? ((x - h) / d + 1) : 0;
  endfunction

  function automatic bit en180_at(longint m, longint d, longint n);
`ifdef CLKEN_PHASE180_EN
    return marks(n * m, d / 2, d) > marks((n - 1) * m, d / 2, d);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    // Channel 0 takes the LSB byte of the INIT vectors: ch0 = 2/2, ch1 = 3/4
    m_mul[0] = 2; m_div[0] = 2;
    m_mul[1] = 3; m_div[1] = 4;
    for (int c = 0; c < CHANNELS; c++) m_n[c] = 0;
    m_cnt    = 0;
    m_locked = 1'b0;
  endtask

  task automatic step(input bit rst, input bit we, input int ch, input int mul, input int div);
    logic [6:0] exp;
    bit         ok;
    @(negedge CLK);
    RST             = rst;
    cfg_bus.cfg_we  = we;
    cfg_bus.cfg_ch  = 3'(ch);
    cfg_bus.cfg_mul = 8'(mul);
    cfg_bus.cfg_div = 8'(div);
    exp = 7'd0;
    if (rst) begin
      model_reset();
    end else begin
      ok = (ch < CHANNELS) && (div != 0) && (mul <= div);
      if (we) begin
        cfg_q.push_back(ok ? 2'b01 : 2'b10);
        exp[1:0] = ok ? 2'b01 : 2'b10;
      end
      for (int c = 0; c < CHANNELS; c++) begin
        if (we && ok && ch == c) begin
          m_mul[c] = mul;
          m_div[c] = div;
          m_n[c]   = 0;
        end else if (m_locked) begin
          m_n[c]++;
          exp[2 + c] = en_at(m_mul[c], m_div[c], m_n[c]);
          exp[4 + c] = en180_at(m_mul[c], m_div[c], m_n[c]);
        end
      end
      if (!m_locked) begin
        m_cnt++;
        if (m_cnt == STARTUP) m_locked = 1'b1;
      end
      exp[6] = m_locked;
    end
    exp_q.push_back(exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0);
  endtask

  // Monitor: every cycle presents strobes; acks/errs are matched against issued writes
  initial begin
    logic [6:0] got, want;
    logic [1:0] cw;
    forever begin
      @(posedge CLK);
      #1;
      got = {LOCKED, en180, en, cfg_bus.cfg_err, cfg_bus.cfg_ack};
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL outputs @%0t: got %b expected %b (locked,en180[1:0],en[1:0],err,ack)",
                   $time, got, want);
        end
      end else if (!sim_done) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow @%0t: DUT output %b with no expectation queued", $time, got);
      end
      if (cfg_bus.cfg_ack || cfg_bus.cfg_err) begin
        checks++;
        if (cfg_q.size() == 0) begin
          errors++;
          $display("FAIL cfg_spurious @%0t: got err/ack %b%b expected no response",
                   $time, cfg_bus.cfg_err, cfg_bus.cfg_ack);
        end else begin
          cw = cfg_q.pop_front();
          if ({cfg_bus.cfg_err, cfg_bus.cfg_ack} !== cw) begin
            errors++;
            $display("FAIL cfg_resp @%0t: got err/ack %b%b expected %b",
                     $time, cfg_bus.cfg_err, cfg_bus.cfg_ack, cw);
          end
        end
      end
    end
  end

  // Lock latency: LOCKED must rise on exactly the 16th edge after each reset release
  int lk_cyc;
  initial begin
    forever begin
      @(negedge RST);
      lk_cyc = 0;
      while (LOCKED !== 1'b1 && lk_cyc < 40) begin
        @(posedge CLK);
        #1;
        lk_cyc++;
      end
      checks++;
      if (lk_cyc != 16) begin
        errors++;
        $display("FAIL lock_latency: got %0d cycles expected 16", lk_cyc);
      end
    end
  end

  initial begin
    int rch, rmul, rdiv;
    RST             = 1'b1;
    cfg_bus.cfg_we  = 1'b0;
    cfg_bus.cfg_ch  = 3'd0;
    cfg_bus.cfg_mul = 8'd0;
    cfg_bus.cfg_div = 8'd0;
    model_reset();

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 0);
    idle(30);                                  // lock, INIT ratios
    step(1'b0, 1'b1, 0, 1, 5);  idle(14);      // ch0 1/5
    step(1'b0, 1'b1, 0, 6, 4);                 // M > D
    step(1'b0, 1'b1, 3, 1, 2);                 // no such channel
    step(1'b0, 1'b1, 1, 1, 0);  idle(8);       // D = 0
    step(1'b0, 1'b1, 0, 1, 4);  idle(12);      // en180 two cycles after en
    step(1'b0, 1'b1, 1, 0, 3);  idle(6);       // idle channel
    step(1'b0, 1'b1, 1, 1, 1);  idle(5);       // en every cycle

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rch  = $urandom_range(0, 3);
        rdiv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
        rmul = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255) : $urandom_range(0, rdiv);
        step(1'b0, 1'b1, rch, rmul, rdiv);
      end else begin
        step(1'b0, 1'b0, 0, 0, 0);
      end
    end

    step(1'b1, 1'b1, 0, 1, 1);  idle(25);      // write under reset is ignored
    step(1'b1, 1'b0, 0, 0, 0);
    step(1'b0, 1'b1, 1, 5, 7);  idle(30);      // write accepted before lock
    idle(3);

    @(posedge CLK);
    #2;
    sim_done = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending cycles expected 0", exp_q.size());
    end
    checks++;
    if (cfg_q.size() != 0) begin
      errors++;
      $display("FAIL cfg_drain: got %0d unanswered writes expected 0", cfg_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
